// File: rtl/bundle_fetch_unit_pkg.sv
// Shared types and constants for the dual-slot bundle fetch front end.
package bundle_fetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned TGT_W  = 11;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned PSEL_W = 2;

  // Field positions inside a 32-bit two-slot bundle
  localparam int unsigned SLOT1_LSB = 0;
  localparam int unsigned SLOT1_MSB = 4;
  localparam int unsigned SLOT2_LSB = 16;
  localparam int unsigned SLOT2_MSB = 20;
  localparam int unsigned TGT_LSB   = 21;
  localparam int unsigned TGT_MSB   = 31;

  // Decoder next-PC select encodings (2'b11 behaves as sequential)
  localparam logic [PSEL_W-1:0] PCSRC_SEQ = 2'b00;
  localparam logic [PSEL_W-1:0] PCSRC_BR  = 2'b01;
  localparam logic [PSEL_W-1:0] PCSRC_JMP = 2'b10;

  localparam logic [XLEN-1:0] NOP_BUNDLE = 32'h0;

  // Bundle layout: target[31:21], slot2 opcode[20:16], slot bodies[15:5], slot1 opcode[4:0]
  typedef struct packed {
    logic [TGT_W-1:0] target;
    logic [OP_W-1:0]  slot2_op;
    logic [10:0]      body;
    logic [OP_W-1:0]  slot1_op;
  } bundle_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/bundle_fetch_unit_next_pc_calc.sv
// Combinational next-PC generator for a retiring bundle (sequential, branch, jump).
module bundle_fetch_unit_next_pc_calc
  import bundle_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0]   ir_pc,
  input  logic [TGT_W-1:0]  target,
  input  logic [PSEL_W-1:0] pc_src,
  output logic [XLEN-1:0]   next_pc_c
);

  localparam int unsigned SEXT_W = XLEN - TGT_W - 2;
  localparam int unsigned REGION_LSB = TGT_W + 2;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_off;

  // Select the next fetch address; all arithmetic wraps modulo 2^32
  always_comb begin
    seq_pc    = ir_pc + XLEN'(4);
    br_off    = {{SEXT_W{target[TGT_W-1]}}, target, 2'b00};
    next_pc_c = seq_pc;
    case (pc_src)
      PCSRC_BR:  next_pc_c = seq_pc + br_off;
      PCSRC_JMP: next_pc_c = {ir_pc[XLEN-1:REGION_LSB], target, 2'b00};
      default:   next_pc_c = seq_pc;
    endcase
  end

endmodule

// File: rtl/bundle_fetch_unit.sv
// Fetch/issue front end: holds the PC, fetches one bundle at a time and issues it on IR.
module bundle_fetch_unit
  import bundle_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic [1:0]       PcSrc,
  output logic [31:0]      IR,
  output logic             ir_valid,
  output logic [31:0]      ir_pc,
  output logic [CNT_W-1:0] bundle_cnt
);

  state_t           state;
  state_t           state_d;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_d;
  bundle_t          ir_q;
  bundle_t          ir_d;
  logic             req_q;
  logic             req_d;
  logic             valid_q;
  logic             valid_d;
  logic [XLEN-1:0]  ir_pc_q;
  logic [XLEN-1:0]  ir_pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [XLEN-1:0]  next_pc_c;
  logic             fetch_done_c;
  logic             retire_c;

  assign imem_req   = req_q;
  assign imem_addr  = pc;
  assign IR         = ir_q;
  assign ir_valid   = valid_q;
  assign ir_pc      = ir_pc_q;
  assign bundle_cnt = cnt_q;

  // Ack only counts while a request is actually outstanding
  assign fetch_done_c = (state == ST_FETCH) && req_q && imem_ack;
  assign retire_c     = (state == ST_ISSUE) && !stall;

  bundle_fetch_unit_next_pc_calc u_next_pc_calc (
    .ir_pc     (ir_pc_q),
    .target    (ir_q.target),
    .pc_src    (PcSrc),
    .next_pc_c (next_pc_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: fetch until acked, issue until a non-stalled cycle
  always_comb begin
    state_d = state;
    case (state)
      ST_FETCH: if (fetch_done_c) state_d = ST_ISSUE;
      ST_ISSUE: if (retire_c)     state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Output/datapath next values; everything holds unless the FSM says otherwise
  always_comb begin
    req_d   = req_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    ir_pc_d = ir_pc_q;
    pc_d    = pc;
    cnt_d   = cnt_q;
    case (state)
      ST_FETCH: begin
        req_d = 1'b1;
        if (fetch_done_c) begin
          req_d   = 1'b0;
          ir_d    = bundle_t'(imem_rdata);
          valid_d = 1'b1;
          ir_pc_d = pc;
        end
      end
      ST_ISSUE: begin
        if (retire_c) begin
          req_d   = 1'b1;
          ir_d    = bundle_t'(NOP_BUNDLE);
          valid_d = 1'b0;
          pc_d    = next_pc_c;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        ir_d    = bundle_t'(NOP_BUNDLE);
        valid_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q   <= 1'b0;
      ir_q    <= bundle_t'(NOP_BUNDLE);
      valid_q <= 1'b0;
      ir_pc_q <= '0;
      pc      <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      req_q   <= req_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
      ir_pc_q <= ir_pc_d;
      pc      <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bundle_fetch_unit.sv
// Directed self-checking bench for bundle_fetch_unit.
module tb_bundle_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  PcSrc;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] ir_pc;
  logic [15:0] bundle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  bundle_fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .PcSrc      (PcSrc),
    .IR         (IR),
    .ir_valid   (ir_valid),
    .ir_pc      (ir_pc),
    .bundle_cnt (bundle_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [10:0] tgt, input logic [20:0] rest);
    mk = {tgt, rest};
  endfunction

  // Wait (bounded) for a fetch request, then check the address and idle IR
  task automatic wait_req(input logic [31:0] addr);
    int k = 0;
    while (!imem_req && k < 8) begin
      tick();
      k++;
    end
    check_eq("req_high", 32'(imem_req), 32'd1);
    check_eq("imem_addr", imem_addr, addr);
    check_eq("fetch_ir", IR, 32'h0);
    check_eq("fetch_valid", 32'(ir_valid), 32'd0);
  endtask

  // Fetch with a one-cycle memory latency and land in ISSUE
  task automatic fetch(input logic [31:0] addr, input logic [31:0] bundle, input logic [1:0] src);
    wait_req(addr);
    tick();
    check_eq("req_hold", 32'(imem_req), 32'd1);
    check_eq("wait_ir", IR, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = bundle;
    PcSrc      = src;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check_eq("issue_valid", 32'(ir_valid), 32'd1);
    check_eq("issue_ir", IR, bundle);
    check_eq("issue_pc", ir_pc, addr);
    check_eq("issue_req", 32'(imem_req), 32'd0);
  endtask

  task automatic retire();
    stall = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check_eq("bundle_cnt", 32'(bundle_cnt), 32'(exp_cnt));
    check_eq("retire_valid", 32'(ir_valid), 32'd0);
    check_eq("retire_ir", IR, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  stall_src [3];
    logic [31:0] held;
    stall_src[0] = 2'b01;
    stall_src[1] = 2'b10;
    stall_src[2] = 2'b00;

    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    PcSrc      = 2'b00;
    exp_cnt    = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, before the first edge out of reset
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h100);
    check_eq("rst_ir", IR, 32'h0);
    check_eq("rst_valid", 32'(ir_valid), 32'd0);
    check_eq("rst_ir_pc", ir_pc, 32'h0);
    check_eq("rst_cnt", 32'(bundle_cnt), 32'd0);
    tick();
    check_eq("req_first_edge", 32'(imem_req), 32'd1);

    // Sequential run 100, 104, 108
    fetch(32'h100, mk(11'h123, 21'h0_1001), 2'b00); retire();
    fetch(32'h104, mk(11'h055, 21'h1_2002), 2'b11); retire();
    fetch(32'h108, mk(11'h2AA, 21'h0_3003), 2'b00); retire();
    check_eq("cnt_three", 32'(bundle_cnt), 32'd3);

    // Jump into 0x200, then branch -2 words and +3 words
    fetch(32'h10C, mk(11'h080, 21'h0_0011), 2'b10); retire();
    fetch(32'h200, mk(11'h7FE, 21'h0_0022), 2'b01); retire();
    fetch(32'h1FC, mk(11'h000, 21'h0_0033), 2'b00); retire();
    fetch(32'h200, mk(11'h003, 21'h0_0044), 2'b01); retire();

    // Walk up to 0x2004 and jump within the 8 KiB region
    fetch(32'h210,  mk(11'h7FF, 21'h0_0055), 2'b10); retire();
    fetch(32'h1FFC, mk(11'h000, 21'h0_0066), 2'b00); retire();
    fetch(32'h2000, mk(11'h000, 21'h0_0077), 2'b00); retire();
    fetch(32'h2004, mk(11'h010, 21'h0_0088), 2'b10); retire();

    // Stall three cycles while PcSrc toggles; release picks the jump
    held  = mk(11'h004, 21'h1_5A5A);
    fetch(32'h2040, held, 2'b01);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PcSrc = stall_src[i];
      tick();
      check_eq("stall_ir", IR, held);
      check_eq("stall_ir_pc", ir_pc, 32'h2040);
      check_eq("stall_cnt", 32'(bundle_cnt), 32'(exp_cnt));
      check_eq("stall_valid", 32'(ir_valid), 32'd1);
    end
    PcSrc = 2'b10;
    retire();

    // Large negative branch, jump to zero, negative wrap, then sequential wrap
    fetch(32'h2010,      mk(11'h400, 21'h0_0099), 2'b01); retire();
    fetch(32'h1014,      mk(11'h000, 21'h0_00AA), 2'b10); retire();
    fetch(32'h0,         mk(11'h7FE, 21'h0_00BB), 2'b01); retire();
    fetch(32'hFFFF_FFFC, mk(11'h1FF, 21'h0_00CC), 2'b00); retire();
    wait_req(32'h0);

    // Reset with a request outstanding and an ack arriving
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    reset      = 1'b1;
    tick();
    check_eq("midrst_req", 32'(imem_req), 32'd0);
    check_eq("midrst_valid", 32'(ir_valid), 32'd0);
    reset = 1'b0;
    check_eq("postrst_addr", imem_addr, 32'h100);
    check_eq("postrst_cnt", 32'(bundle_cnt), 32'd0);
    check_eq("postrst_ir", IR, 32'h0);
    tick();
    imem_ack = 1'b0;
    check_eq("stale_valid", 32'(ir_valid), 32'd0);
    check_eq("stale_ir", IR, 32'h0);
    check_eq("stale_req", 32'(imem_req), 32'd1);
    exp_cnt = 16'd0;
    fetch(32'h100, mk(11'h001, 21'h0_00DD), 2'b00); retire();
    wait_req(32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
